// File: rtl/cpu_alu_pkg.sv
// ALU control codes shared by the ALU decoder, ALU and HI/LO multiply/divide unit.
package cpu_alu_pkg;

  localparam logic [4:0] ALU_MULTU = 5'b00111;
  localparam logic [4:0] ALU_MULT  = 5'b01000;
  localparam logic [4:0] ALU_DIV   = 5'b01111;
  localparam logic [4:0] ALU_DIVU  = 5'b10000;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code == ALU_MULTU) || (code == ALU_MULT) ||
           (code == ALU_DIV)   || (code == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with the HI/LO register pair.
// One shift-add or restoring-divide step per cycle, sign fix-up, then HI/LO write.
//
// state | meaning
// IDLE  | waiting; MTHI/MTLO write directly, mult/div accepted here
// RUN   | one multiply/divide iteration per cycle, counter 0..WIDTH-1
// FIX   | sign correction and HI/LO write, then back to IDLE
module hilo_muldiv
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
  logic               op_div, neg_res, neg_rem, div_zero;
  logic               accept_md, write_hi, write_lo;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   rem, quo, rem_nxt;
  logic               div_bit;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fix;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && is_muldiv(alucontrol)) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode; only IDLE looks at start
  always_comb begin
    busy      = (state != S_IDLE);
    accept_md = (state == S_IDLE) && start && is_muldiv(alucontrol);
    write_hi  = (state == S_IDLE) && start && (alucontrol == ALU_MTHI);
    write_lo  = (state == S_IDLE) && start && (alucontrol == ALU_MTLO);
  end

  assign a_neg = is_signed_op(alucontrol) && srca[WIDTH-1];
  assign b_neg = is_signed_op(alucontrol) && srcb[WIDTH-1];

  // Restoring divide step: remainder in acc upper half, quotient in lower half
  always_comb begin
    rem     = acc[2*WIDTH-1:WIDTH];
    quo     = acc[WIDTH-1:0];
    div_bit = a_mag[CNT_LAST - cnt];
    trial   = {rem, div_bit} - {1'b0, b_mag};
    rem_nxt = trial[WIDTH] ? {rem[WIDTH-2:0], div_bit} : trial[WIDTH-1:0];
  end

  assign prod_fix = neg_res ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      a_raw    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      if (write_hi) hi <= srca;
      if (write_lo) lo <= srca;
      if (accept_md) begin
        a_mag    <= a_neg ? (~srca + 1'b1) : srca;
        b_mag    <= b_neg ? (~srcb + 1'b1) : srcb;
        a_raw    <= srca;
        op_div   <= is_div_op(alucontrol);
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        div_zero <= is_div_op(alucontrol) && (srcb == '0);
        acc      <= '0;
        cnt      <= '0;
      end
      if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        if (op_div)
          acc <= {rem_nxt, quo[WIDTH-2:0], ~trial[WIDTH]};
        else if (b_mag[cnt])
          acc <= acc + ({{WIDTH{1'b0}}, a_mag} << cnt);
      end
      if (state == S_FIX) begin
        if (!op_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= neg_rem ? (~rem + 1'b1) : rem;
          lo <= neg_res ? (~quo + 1'b1) : quo;
        end
      end
    end
  end

endmodule
